cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Shares the single ROB/RS/LSB result broadcast (CDB) between the ALU and the LSB load path.
//  Each source has a small FIFO; a round-robin arbiter issues one registered broadcast per cycle.
//  Per-source order is preserved. Everything is discarded on a misprediction clear.
//  Sits between the execution units and the ROB result-write / RS-LSB wakeup ports.
// PARAMETERS
//  ROB_POS_W   4   ROB index width; wrapped tag = {valid bit, index}, width ROB_POS_W+1
//  DATA_W      32  result value width
//  ADDR_W      32  branch/jump target width
//  FIFO_DEPTH  2   entries per source FIFO (power of 2, >=2)
// PORTS
//  clk          in   1            clock
//  rst          in   1            synchronous active-high reset
//  rdy          in   1            global ready; low = freeze all state
//  clr          in   1            misprediction flush from ROB
//  alu_valid    in   1            ALU result push
//  alu_rob_pos  in   ROB_POS_W+1  ALU result tag
//  alu_val      in   DATA_W       ALU result value
//  alu_jump     in   1            ALU branch/jalr taken
//  alu_pc       in   ADDR_W       ALU resolved target pc
//  alu_full     out  1            ALU FIFO holds FIFO_DEPTH entries
//  lsb_valid    in   1            load result push
//  lsb_rob_pos  in   ROB_POS_W+1  load tag
//  lsb_val      in   DATA_W       load value
//  lsb_full     out  1            LSB FIFO holds FIFO_DEPTH entries
//  cdb_valid    out  1            broadcast valid
//  cdb_src      out  1            0 = ALU, 1 = LSB
//  cdb_rob_pos  out  ROB_POS_W+1  broadcast tag
//  cdb_val      out  DATA_W       broadcast value
//  cdb_jump     out  1            taken flag (0 for LSB)
//  cdb_pc       out  ADDR_W       target pc (0 for LSB)
//  overflow     out  1            1-cycle pulse: push dropped because the FIFO was full
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): FIFOs empty, rr_last=LSB (ALU wins the first contest), all outputs 0.
//  rdy=0: all state and outputs hold; inputs ignored. rst overrides rdy.
//  clr=1 (rdy=1): FIFOs emptied; next-cycle cdb_valid=0, overflow=0; pushes in that cycle are dropped; rr_last unchanged.
//  Candidate per source: the FIFO head if the FIFO is non-empty, else the same-cycle input if valid (bypass).
//  Grant: one candidate only -> grant it. Both -> grant the source != rr_last. rr_last <= granted source.
//  Granted entry is registered onto cdb_* at that edge. Bypassed input: latency 1 cycle (push edge N, visible N..N+1).
//  cdb_valid=0 when no candidate; the other cdb_* fields are then don't-care and are driven to 0.
//  A non-granted valid input is written to its FIFO tail in the same edge.
//  If the FIFO head is granted, the head is popped in the same edge.
//  Push is accepted iff count<FIFO_DEPTH, or that FIFO is popped in the same edge.
//  Otherwise the push is dropped and overflow=1 next cycle.
//  Simultaneous push+pop on one FIFO: count unchanged; pointers wrap modulo FIFO_DEPTH.
//  alu_full/lsb_full are registered: (count==FIFO_DEPTH) after the edge.
//  Sources must not push while their full flag is high.
//  cdb_* are flops; no combinational path from inputs to outputs.
//  Tags pass through unmodified, including bit ROB_POS_W.
// TESTING
//  1 reset -> cdb_valid=0, alu_full=lsb_full=0, overflow=0; hold 3 cycles idle -> unchanged.
//  2 ALU push only (pos=5'h13, val=32'hAB, jump=1, pc=32'h100) -> next cycle cdb_valid=1, src=0, pos=5'h13, val=32'hAB, jump=1, pc=32'h100.
//  3 ALU and LSB push together, 3 cycles each -> cdb_src sequence 0,1,0,1,0,1; each source's values in push order.
//  4 ALU push every cycle while LSB pushes continuously, FIFO_DEPTH=2 -> lsb_full asserts, and the LSB push issued while full yields overflow=1 for 1 cycle.
//  5 2 ALU entries queued, then clr=1 with a same-cycle lsb push -> next cycle cdb_valid=0, alu_full=0; no queued entry is ever broadcast.
//  6 rdy=0 for 4 cycles with cdb_valid=1 and a queued entry -> outputs frozen; rdy=1 -> the queued entry is broadcast the next cycle.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: small per-source result FIFOs (ALU, LSB load) feed one
// registered broadcast per cycle, round-robin between sources, flushed on clr.
module cdb_arbiter #(
    parameter int ROB_POS_W  = 4,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 clr,
    input  logic                 alu_valid,
    input  logic [ROB_POS_W:0]   alu_rob_pos,
    input  logic [DATA_W-1:0]    alu_val,
    input  logic                 alu_jump,
    input  logic [ADDR_W-1:0]    alu_pc,
    output logic                 alu_full,
    input  logic                 lsb_valid,
    input  logic [ROB_POS_W:0]   lsb_rob_pos,
    input  logic [DATA_W-1:0]    lsb_val,
    output logic                 lsb_full,
    output logic                 cdb_valid,
    output logic                 cdb_src,
    output logic [ROB_POS_W:0]   cdb_rob_pos,
    output logic [DATA_W-1:0]    cdb_val,
    output logic                 cdb_jump,
    output logic [ADDR_W-1:0]    cdb_pc,
    output logic                 overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_LSB = 1'b1;

    typedef struct packed {
        logic [ROB_POS_W:0] rob_pos;
        logic [DATA_W-1:0]  val;
        logic               jump;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    entry_t           mem_q  [2][FIFO_DEPTH];
    entry_t           mem_d  [2][FIFO_DEPTH];
    logic [PTR_W-1:0] head_q [2];
    logic [PTR_W-1:0] head_d [2];
    logic [PTR_W-1:0] tail_q [2];
    logic [PTR_W-1:0] tail_d [2];
    logic [CNT_W-1:0] cnt_q  [2];
    logic [CNT_W-1:0] cnt_d  [2];
    logic [1:0]       full_q, full_d;
    logic             rr_last_q, rr_last_d;
    logic             cdb_valid_q, cdb_valid_d;
    logic             cdb_src_q, cdb_src_d;
    entry_t           cdb_q, cdb_d;
    logic             overflow_q, overflow_d;

    entry_t     in_ent   [2];
    entry_t     cand_ent [2];
    logic [1:0] in_vld, cand, granted, pop, push_req, accept, drop;
    logic       grant_vld, grant_src;

    // Index 0 is the ALU source, index 1 the LSB load path.
    always_comb begin
        in_ent[0].rob_pos = alu_rob_pos;
        in_ent[0].val     = alu_val;
        in_ent[0].jump    = alu_jump;
        in_ent[0].pc      = alu_pc;
        in_ent[1].rob_pos = lsb_rob_pos;
        in_ent[1].val     = lsb_val;
        in_ent[1].jump    = 1'b0;
        in_ent[1].pc      = '0;
        in_vld            = {lsb_valid, alu_valid};
    end

    // A non-empty FIFO offers its head; an empty one lets the live input bypass.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            cand[s]     = (cnt_q[s] != '0) || in_vld[s];
            cand_ent[s] = (cnt_q[s] != '0) ? mem_q[s][head_q[s]] : in_ent[s];
        end
        grant_vld = cand[0] | cand[1];
        grant_src = (cand[0] && cand[1]) ? ~rr_last_q : ~cand[0];
        granted   = {grant_vld & grant_src, grant_vld & ~grant_src};
        for (int s = 0; s < 2; s++) begin
            pop[s]      = granted[s] && (cnt_q[s] != '0);
            push_req[s] = in_vld[s] && !(granted[s] && (cnt_q[s] == '0));
            accept[s]   = push_req[s] && ((cnt_q[s] != DEPTH_C) || pop[s]);
            drop[s]     = push_req[s] && !accept[s];
        end
    end

    always_comb begin
        mem_d       = mem_q;
        head_d      = head_q;
        tail_d      = tail_q;
        cnt_d       = cnt_q;
        full_d      = full_q;
        rr_last_d   = rr_last_q;
        cdb_valid_d = cdb_valid_q;
        cdb_src_d   = cdb_src_q;
        cdb_d       = cdb_q;
        overflow_d  = overflow_q;
        if (rdy) begin
            if (clr) begin
                for (int s = 0; s < 2; s++) begin
                    head_d[s] = '0;
                    tail_d[s] = '0;
                    cnt_d[s]  = '0;
                end
                full_d      = '0;
                cdb_valid_d = 1'b0;
                cdb_src_d   = SRC_ALU;
                cdb_d       = '0;
                overflow_d  = 1'b0;
            end else begin
                for (int s = 0; s < 2; s++) begin
                    if (pop[s]) begin
                        head_d[s] = head_q[s] + PTR_W'(1);
                    end
                    if (accept[s]) begin
                        mem_d[s][tail_q[s]] = in_ent[s];
                        tail_d[s]           = tail_q[s] + PTR_W'(1);
                    end
                    cnt_d[s]  = cnt_q[s] + CNT_W'(accept[s]) - CNT_W'(pop[s]);
                    full_d[s] = (cnt_d[s] == DEPTH_C);
                end
                cdb_valid_d = grant_vld;
                cdb_src_d   = grant_vld & grant_src;
                cdb_d       = grant_vld ? cand_ent[grant_src] : '0;
                rr_last_d   = grant_vld ? grant_src : rr_last_q;
                overflow_d  = |drop;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                head_q[s] <= '0;
                tail_q[s] <= '0;
                cnt_q[s]  <= '0;
            end
            full_q      <= '0;
            rr_last_q   <= SRC_LSB;
            cdb_valid_q <= 1'b0;
            cdb_src_q   <= SRC_ALU;
            cdb_q       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            rr_last_q   <= rr_last_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_src_q   <= cdb_src_d;
            cdb_q       <= cdb_d;
            overflow_q  <= overflow_d;
        end
    end

    // FIFO storage is data only; occupancy is tracked by the counters above.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign alu_full    = full_q[0];
    assign lsb_full    = full_q[1];
    assign cdb_valid   = cdb_valid_q;
    assign cdb_src     = cdb_src_q;
    assign cdb_rob_pos = cdb_q.rob_pos;
    assign cdb_val     = cdb_q.val;
    assign cdb_jump    = cdb_q.jump;
    assign cdb_pc      = cdb_q.pc;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, hand-written corner sequences and
// random traffic checked against a queue-based reference model.
module tb_cdb_arbiter;
    localparam int ROB_POS_W  = 4;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int FIFO_DEPTH = 2;

    typedef logic [74:0] bus_t;

    logic              clk = 1'b0;
    logic              rst, rdy, clr;
    logic              alu_valid, alu_jump, alu_full;
    logic [4:0]        alu_rob_pos;
    logic [31:0]       alu_val, alu_pc;
    logic              lsb_valid, lsb_full;
    logic [4:0]        lsb_rob_pos;
    logic [31:0]       lsb_val;
    logic              cdb_valid, cdb_src, cdb_jump, overflow;
    logic [4:0]        cdb_rob_pos;
    logic [31:0]       cdb_val, cdb_pc;

    always #5 clk = ~clk;

    cdb_arbiter #(
        .ROB_POS_W(ROB_POS_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .alu_valid(alu_valid), .alu_rob_pos(alu_rob_pos), .alu_val(alu_val),
        .alu_jump(alu_jump), .alu_pc(alu_pc), .alu_full(alu_full),
        .lsb_valid(lsb_valid), .lsb_rob_pos(lsb_rob_pos), .lsb_val(lsb_val),
        .lsb_full(lsb_full),
        .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_rob_pos(cdb_rob_pos),
        .cdb_val(cdb_val), .cdb_jump(cdb_jump), .cdb_pc(cdb_pc), .overflow(overflow)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: one queue per source, inputs staged at the back, the
    // oldest entry of the round-robin winner broadcast, and anything beyond
    // FIFO_DEPTH left behind is a dropped push.
    typedef struct packed {
        logic [4:0]  pos;
        logic [31:0] val;
        logic        jump;
        logic [31:0] pc;
    } ent_t;

    ent_t aq[$];
    ent_t lq[$];
    logic rr_lsb_last;
    logic m_valid, m_src, m_ovf, m_afull, m_lfull;
    ent_t m_ent;

    function automatic bus_t mkbus(input logic v, input logic s, input logic [4:0] pos,
                                   input logic [31:0] val, input logic j, input logic [31:0] pc,
                                   input logic af, input logic lf, input logic ov);
        return {v, s, pos, val, j, pc, af, lf, ov};
    endfunction

    function automatic bus_t dut_bus();
        return mkbus(cdb_valid, cdb_src, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc,
                     alu_full, lsb_full, overflow);
    endfunction

    function automatic bus_t model_bus();
        return mkbus(m_valid, m_src, m_ent.pos, m_ent.val, m_ent.jump, m_ent.pc,
                     m_afull, m_lfull, m_ovf);
    endfunction

    task automatic model_step();
        ent_t e;
        if (rst) begin
            aq.delete(); lq.delete();
            rr_lsb_last = 1'b1;
            m_valid = 0; m_src = 0; m_ent = '0; m_ovf = 0; m_afull = 0; m_lfull = 0;
        end else if (rdy) begin
            if (clr) begin
                aq.delete(); lq.delete();
                m_valid = 0; m_src = 0; m_ent = '0; m_ovf = 0; m_afull = 0; m_lfull = 0;
            end else begin
                if (alu_valid) begin
                    e.pos = alu_rob_pos; e.val = alu_val; e.jump = alu_jump; e.pc = alu_pc;
                    aq.push_back(e);
                end
                if (lsb_valid) begin
                    e.pos = lsb_rob_pos; e.val = lsb_val; e.jump = 1'b0; e.pc = '0;
                    lq.push_back(e);
                end
                m_valid = 0; m_src = 0; m_ent = '0;
                if (aq.size() > 0 && (lq.size() == 0 || rr_lsb_last)) begin
                    m_valid = 1; m_src = 0; m_ent = aq.pop_front(); rr_lsb_last = 1'b0;
                end else if (lq.size() > 0) begin
                    m_valid = 1; m_src = 1; m_ent = lq.pop_front(); rr_lsb_last = 1'b1;
                end
                m_ovf = 0;
                if (aq.size() > FIFO_DEPTH) begin void'(aq.pop_back()); m_ovf = 1; end
                if (lq.size() > FIFO_DEPTH) begin void'(lq.pop_back()); m_ovf = 1; end
                m_afull = (aq.size() == FIFO_DEPTH);
                m_lfull = (lq.size() == FIFO_DEPTH);
            end
        end
    endtask

    task automatic check(input string name, input bus_t act, input bus_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b want=%b", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rd, input logic c,
                         input logic av, input logic [4:0] ap, input logic [31:0] aval,
                         input logic aj, input logic [31:0] apc,
                         input logic lv, input logic [4:0] lp, input logic [31:0] lval);
        rst = r; rdy = rd; clr = c;
        alu_valid = av; alu_rob_pos = ap; alu_val = aval; alu_jump = aj; alu_pc = apc;
        lsb_valid = lv; lsb_rob_pos = lp; lsb_val = lval;
    endtask

    task automatic idle();
        drive(0, 1, 0, 0, 5'h0, 32'h0, 0, 32'h0, 0, 5'h0, 32'h0);
    endtask

    task automatic do_reset();
        drive(1, 1, 0, 0, 5'h0, 32'h0, 0, 32'h0, 0, 5'h0, 32'h0);
    endtask

    task automatic tick(input bit use_model, input string name);
        @(posedge clk);
        model_step();
        #1;
        if (use_model) check(name, dut_bus(), model_bus());
    endtask

    typedef struct packed {
        logic        r, rd, c, av;
        logic [4:0]  ap;
        logic [31:0] aval;
        logic        aj;
        logic [31:0] apc;
        logic        lv;
        logic [4:0]  lp;
        logic [31:0] lval;
        bus_t        exp;
    } vec_t;

    function automatic vec_t mkvec(input logic r, input logic av, input logic [4:0] ap,
                                   input logic [31:0] aval, input logic aj, input logic [31:0] apc,
                                   input logic lv, input logic [4:0] lp, input logic [31:0] lval,
                                   input bus_t exp);
        vec_t v;
        v.r = r; v.rd = 1'b1; v.c = 1'b0; v.av = av; v.ap = ap; v.aval = aval; v.aj = aj;
        v.apc = apc; v.lv = lv; v.lp = lp; v.lval = lval; v.exp = exp;
        return v;
    endfunction

    vec_t tbl [14];

    initial begin
        bus_t zero_bus;
        bus_t held;
        zero_bus = '0;

        tbl[0]  = mkvec(1, 0, 5'h00, 32'h00, 0, 32'h000, 0, 5'h00, 32'h00, zero_bus);
        tbl[1]  = mkvec(0, 0, 5'h00, 32'h00, 0, 32'h000, 0, 5'h00, 32'h00, zero_bus);
        tbl[2]  = mkvec(0, 0, 5'h00, 32'h00, 0, 32'h000, 0, 5'h00, 32'h00, zero_bus);
        tbl[3]  = mkvec(0, 0, 5'h00, 32'h00, 0, 32'h000, 0, 5'h00, 32'h00, zero_bus);
        tbl[4]  = mkvec(0, 1, 5'h13, 32'hAB, 1, 32'h100, 0, 5'h00, 32'h00,
                        mkbus(1, 0, 5'h13, 32'hAB, 1, 32'h100, 0, 0, 0));
        tbl[5]  = mkvec(0, 0, 5'h00, 32'h00, 0, 32'h000, 0, 5'h00, 32'h00, zero_bus);
        tbl[6]  = mkvec(1, 0, 5'h00, 32'h00, 0, 32'h000, 0, 5'h00, 32'h00, zero_bus);
        tbl[7]  = mkvec(0, 1, 5'h01, 32'hA1, 0, 32'h200, 1, 5'h11, 32'hB1,
                        mkbus(1, 0, 5'h01, 32'hA1, 0, 32'h200, 0, 0, 0));
        tbl[8]  = mkvec(0, 1, 5'h02, 32'hA2, 1, 32'h204, 1, 5'h12, 32'hB2,
                        mkbus(1, 1, 5'h11, 32'hB1, 0, 32'h000, 0, 0, 0));
        tbl[9]  = mkvec(0, 1, 5'h1F, 32'hA3, 0, 32'h208, 1, 5'h10, 32'hB3,
                        mkbus(1, 0, 5'h02, 32'hA2, 1, 32'h204, 0, 1, 0));
        tbl[10] = mkvec(0, 0, 5'h00, 32'h00, 0, 32'h000, 0, 5'h00, 32'h00,
                        mkbus(1, 1, 5'h12, 32'hB2, 0, 32'h000, 0, 0, 0));
        tbl[11] = mkvec(0, 0, 5'h00, 32'h00, 0, 32'h000, 0, 5'h00, 32'h00,
                        mkbus(1, 0, 5'h1F, 32'hA3, 0, 32'h208, 0, 0, 0));
        tbl[12] = mkvec(0, 0, 5'h00, 32'h00, 0, 32'h000, 0, 5'h00, 32'h00,
                        mkbus(1, 1, 5'h10, 32'hB3, 0, 32'h000, 0, 0, 0));
        tbl[13] = mkvec(0, 0, 5'h00, 32'h00, 0, 32'h000, 0, 5'h00, 32'h00, zero_bus);

        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].r, tbl[i].rd, tbl[i].c, tbl[i].av, tbl[i].ap, tbl[i].aval,
                  tbl[i].aj, tbl[i].apc, tbl[i].lv, tbl[i].lp, tbl[i].lval);
            tick(0, "");
            check($sformatf("vec%0d", i), dut_bus(), tbl[i].exp);
        end

        // Both sources push back to back until both FIFOs fill and a push is dropped.
        do_reset();
        tick(1, "ovf_reset");
        for (int c = 0; c < 5; c++) begin
            drive(0, 1, 0, 1, 5'(c), 32'h1000 + 32'(c), c[0], 32'h400 + 32'(c),
                  1, 5'h10 + 5'(c), 32'h2000 + 32'(c));
            tick(1, "ovf_seq");
            if (c == 2) check1("lsb_full_asserts", lsb_full, 1'b1);
            if (c == 3) check1("ovf_not_yet", overflow, 1'b0);
            if (c == 4) check1("overflow_pulse", overflow, 1'b1);
        end
        idle();
        tick(1, "ovf_idle");
        check1("overflow_clears", overflow, 1'b0);
        for (int c = 0; c < 5; c++) tick(1, "ovf_drain");

        // Flush with entries queued and a same-cycle LSB push.
        do_reset();
        tick(1, "clr_reset");
        for (int c = 0; c < 4; c++) begin
            drive(0, 1, 0, 1, 5'h08 + 5'(c), 32'h3000 + 32'(c), 1, 32'h500,
                  1, 5'h18 + 5'(c), 32'h4000 + 32'(c));
            tick(1, "clr_fill");
        end
        check1("alu_full_before_clr", alu_full, 1'b1);
        drive(0, 1, 1, 0, 5'h0, 32'h0, 0, 32'h0, 1, 5'h1C, 32'h4444);
        tick(1, "clr_edge");
        check("clr_outputs", dut_bus(), zero_bus);
        idle();
        for (int c = 0; c < 4; c++) begin
            tick(1, "clr_after");
            check1("clr_no_stale", cdb_valid, 1'b0);
        end

        // Freeze with a live broadcast and a queued LSB entry.
        do_reset();
        tick(1, "frz_reset");
        drive(0, 1, 0, 1, 5'h07, 32'h77, 1, 32'h300, 1, 5'h1A, 32'h66);
        tick(1, "frz_load");
        held = mkbus(1, 0, 5'h07, 32'h77, 1, 32'h300, 0, 0, 0);
        check("frz_first", dut_bus(), held);
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, c == 2, 1, 5'($urandom), $urandom, 1'($urandom), $urandom,
                  1, 5'($urandom), $urandom);
            tick(1, "frz_model");
            check("frz_hold", dut_bus(), held);
        end
        idle();
        tick(1, "frz_resume");
        check("frz_release", dut_bus(), mkbus(1, 1, 5'h1A, 32'h66, 0, 32'h0, 0, 0, 0));
        tick(1, "frz_empty");
        check("frz_drained", dut_bus(), zero_bus);

        // Random traffic against the reference model.
        do_reset();
        tick(1, "rand_reset");
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 29) == 0,
                  1'($urandom), 5'($urandom), $urandom, 1'($urandom), $urandom,
                  1'($urandom), 5'($urandom), $urandom);
            tick(1, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
